tx_arbiter: RTL and testbench

TX_ARBITER -- requirements
Module: tx_arbiter

---
 rtl/tx_arbiter.sv | 110 +++++++++++
 tb/tb_tx_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_arbiter.sv
// tx_arbiter: two-requester arbiter that serialises a 32-bit payload as 16 RMII dibits, then holds an inter-frame gap.
// Define TX_ARBITER_FIXED_PRIORITY_EN to use fixed priority (requester 0 wins ties) instead of round-robin.
module tx_arbiter #(
  parameter int IFG_CYCLES = 48
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [1:0]  req,
  input  logic [31:0] data0,
  input  logic [31:0] data1,
  output logic [1:0]  ack,
  output logic        axiov,
  output logic [1:0]  axiod,
  output logic        busy
);

  localparam int GAP_W = $clog2(IFG_CYCLES) + 1;
  // Gap count one edge before it reaches IFG_CYCLES-1; only consulted when IFG_CYCLES > 1.
  localparam logic [GAP_W-1:0] GAP_PRE    = GAP_W'(IFG_CYCLES - 2);
  localparam logic [4:0]       LAST_DIBIT = 5'd16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t           state_reg;
  logic [4:0]       dibit_cnt_reg;
  logic [GAP_W-1:0] gap_cnt_reg;
  logic [31:0]      shift_reg;
  logic             winner;
  logic [31:0]      payload;

`ifdef TX_ARBITER_FIXED_PRIORITY_EN
  assign winner = ~req[0];
`else
  logic last_grant_reg;
  // On a tie the requester that was not served last wins; a lone request always wins.
  assign winner = (req == 2'b11) ? ~last_grant_reg : req[1];
`endif

  assign payload = winner ? data1 : data0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg     <= IDLE;
      ack           <= 2'b00;
      axiov         <= 1'b0;
      axiod         <= 2'b00;
      busy          <= 1'b0;
      dibit_cnt_reg <= '0;
      gap_cnt_reg   <= '0;
      shift_reg     <= '0;
`ifndef TX_ARBITER_FIXED_PRIORITY_EN
      last_grant_reg <= 1'b1;
`endif
    end else begin
      ack <= 2'b00;
      case (state_reg)
        IDLE: begin
          if (req != 2'b00) begin
            ack           <= winner ? 2'b10 : 2'b01;
            axiov         <= 1'b1;
            axiod         <= payload[31:30];
            shift_reg     <= {payload[29:0], 2'b00};
            dibit_cnt_reg <= 5'd1;
            busy          <= 1'b1;
            state_reg     <= SEND;
`ifndef TX_ARBITER_FIXED_PRIORITY_EN
            last_grant_reg <= winner;
`endif
          end
        end
        SEND: begin
          if (dibit_cnt_reg == LAST_DIBIT) begin
            axiov       <= 1'b0;
            axiod       <= 2'b00;
            gap_cnt_reg <= '0;
            // A one-cycle gap is just the IDLE cycle itself, so skip GAP entirely.
            if (IFG_CYCLES <= 1) begin
              busy      <= 1'b0;
              state_reg <= IDLE;
            end else begin
              state_reg <= GAP;
            end
          end else begin
            axiod         <= shift_reg[31:30];
            shift_reg     <= {shift_reg[29:0], 2'b00};
            dibit_cnt_reg <= dibit_cnt_reg + 5'd1;
          end
        end
        GAP: begin
          gap_cnt_reg <= gap_cnt_reg + 1'b1;
          if (gap_cnt_reg == GAP_PRE) begin
            busy      <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: begin
          axiov     <= 1'b0;
          axiod     <= 2'b00;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_arbiter.sv
// tb_tx_arbiter: table-driven frames, corner-case sequences and randomized traffic for tx_arbiter,
// checked cycle by cycle against a frame-level queue model; a second instance uses IFG_CYCLES=1.
module tb_tx_arbiter;

  localparam int IFG = 48;

  logic        clk = 1'b0;
  logic        rstn, rstn_b;
  logic [1:0]  req, req_b;
  logic [31:0] data0, data1, data0_b, data1_b;
  logic [1:0]  ack, ack_b, axiod, axiod_b;
  logic        axiov, axiov_b, busy, busy_b;

  always #5 clk = ~clk;

  tx_arbiter #(.IFG_CYCLES(IFG)) dut (
    .clk(clk), .rstn(rstn), .req(req), .data0(data0), .data1(data1),
    .ack(ack), .axiov(axiov), .axiod(axiod), .busy(busy)
  );

  tx_arbiter #(.IFG_CYCLES(1)) dut_b (
    .clk(clk), .rstn(rstn_b), .req(req_b), .data0(data0_b), .data1(data1_b),
    .ack(ack_b), .axiov(axiov_b), .axiod(axiod_b), .busy(busy_b)
  );

  typedef struct packed {
    logic [1:0] ack;
    logic       v;
    logic [1:0] d;
    logic       busy;
  } out_t;

  typedef struct {
    logic [1:0]  req;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  exp_ack;
    logic [31:0] exp_word;
  } vec_t;

  out_t exp_q[$];
  out_t cur;
  logic m_last;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  // Frame-level model: a grant in idle queues the whole frame (16 dibits, then IFG-1 busy gap cycles).
  task automatic model_edge();
    int          w;
    logic [31:0] p;
    out_t        r;
    if (!cur.busy && req != 2'b00) begin
`ifdef TX_ARBITER_FIXED_PRIORITY_EN
      w = req[0] ? 0 : 1;
`else
      if (req == 2'b11) w = 1 - int'(m_last);
      else              w = req[0] ? 0 : 1;
`endif
      m_last = (w == 1);
      p = (w == 1) ? data1 : data0;
      for (int k = 0; k < 16; k++) begin
        r      = '0;
        r.ack  = (k == 0) ? ((w == 1) ? 2'b10 : 2'b01) : 2'b00;
        r.v    = 1'b1;
        r.d    = 2'((p >> (30 - 2 * k)) & 32'h3);
        r.busy = 1'b1;
        exp_q.push_back(r);
      end
      for (int k = 0; k < IFG - 1; k++) begin
        r      = '0;
        r.busy = 1'b1;
        exp_q.push_back(r);
      end
    end
    if (exp_q.size() > 0) cur = exp_q.pop_front();
    else                  cur = '0;
  endtask

  task automatic model_reset();
    exp_q.delete();
    cur    = '0;
    m_last = 1'b1;
  endtask

  task automatic check_out(input string name);
    out_t got;
    got.ack  = ack;
    got.v    = axiov;
    got.d    = axiod;
    got.busy = busy;
    n_tests++;
    if (got !== cur) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got ack=%b v=%b d=%0d busy=%b, expected ack=%b v=%b d=%0d busy=%b",
               name, cyc, got.ack, got.v, got.d, got.busy, cur.ack, cur.v, cur.d, cur.busy);
    end
  endtask

  task automatic expect_eq(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    check_out("cycle");
  endtask

  // Called at edge+1: asserts reset between edges and checks the outputs clear without a clock edge.
  task automatic pulse_reset(input string name);
    rstn = 1'b0;
    #2;
    expect_eq(name, {26'd0, ack, axiov, axiod, busy}, 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    model_reset();
  endtask

  task automatic drain();
    req = 2'b00;
    for (int c = 0; c < 200 && busy; c++) step();
    expect_eq("drain_idle", {31'd0, busy}, 32'd0);
  endtask

  task automatic run_frame(input logic [1:0] r, input logic [31:0] d0, input logic [31:0] d1,
                           output logic [1:0] fack, output logic [31:0] word,
                           output int nv, output int ngap);
    req = r; data0 = d0; data1 = d1;
    step();
    fack = ack;
    word = {30'd0, axiod};
    nv   = axiov ? 1 : 0;
    req  = 2'b00;
    data0 = ~d0;
    data1 = ~d1;
    for (int c = 0; c < 40 && axiov; c++) begin
      step();
      if (axiov) begin
        word = {word[29:0], axiod};
        nv++;
      end
    end
    ngap = (busy && !axiov) ? 1 : 0;
    for (int c = 0; c < 200 && busy; c++) begin
      step();
      if (busy) ngap++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[6];
    logic [1:0]  fack;
    logic [31:0] word;
    int          nv, ngap, t, r;
    int          gcyc[$];
    int          gwin[$];
    int          starts[$];
    int          idle_b;

    rstn = 1'b0; rstn_b = 1'b0;
    req = 2'b00; req_b = 2'b00;
    data0 = '0; data1 = '0; data0_b = '0; data1_b = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    expect_eq("reset_state", {26'd0, ack, axiov, axiod, busy}, 32'd0);
    expect_eq("reset_state_b", {26'd0, ack_b, axiov_b, axiod_b, busy_b}, 32'd0);
    rstn = 1'b1; rstn_b = 1'b1;
    step();
    step();

    // Back-to-back frames with a one-cycle inter-frame gap.
    req_b = 2'b01; data0_b = 32'hF0F0_F0F0; data1_b = 32'h0;
    idle_b = 0;
    for (int c = 0; c < 80; c++) begin
      step();
      if (ack_b != 2'b00) begin
        starts.push_back(c);
        expect_eq("ifg1_ack", {30'd0, ack_b}, 32'd1);
      end
      if (starts.size() > 0 && starts.size() < 4 && !axiov_b) idle_b++;
    end
    req_b = 2'b00;
    expect_eq("ifg1_frames", (starts.size() >= 4) ? 32'd1 : 32'd0, 32'd1);
    for (int i = 0; i < 3 && i + 1 < starts.size(); i++)
      expect_eq("ifg1_spacing", starts[i+1] - starts[i], 32'd17);
    expect_eq("ifg1_idle_cycles", idle_b, 32'd3);
    for (int c = 0; c < 40 && busy_b; c++) step();
    expect_eq("ifg1_drain", {31'd0, busy_b}, 32'd0);

    tbl[0] = '{2'b01, 32'hFEED_BEEF, 32'h0000_0000, 2'b01, 32'hFEED_BEEF};
`ifdef TX_ARBITER_FIXED_PRIORITY_EN
    tbl[1] = '{2'b11, 32'h0000_0000, 32'hFFFF_FFFF, 2'b01, 32'h0000_0000};
`else
    tbl[1] = '{2'b11, 32'h0000_0000, 32'hFFFF_FFFF, 2'b10, 32'hFFFF_FFFF};
`endif
    tbl[2] = '{2'b11, 32'h1357_9BDF, 32'h2468_ACE0, 2'b01, 32'h1357_9BDF};
    tbl[3] = '{2'b10, 32'hAAAA_AAAA, 32'hC3C3_5A5A, 2'b10, 32'hC3C3_5A5A};
    tbl[4] = '{2'b11, 32'h0F0F_F0F0, 32'hDEAD_BEEF, 2'b01, 32'h0F0F_F0F0};
`ifdef TX_ARBITER_FIXED_PRIORITY_EN
    tbl[5] = '{2'b11, 32'h0000_0001, 32'h8000_0001, 2'b01, 32'h0000_0001};
`else
    tbl[5] = '{2'b11, 32'h0000_0001, 32'h8000_0001, 2'b10, 32'h8000_0001};
`endif

    for (int i = 0; i < 6; i++) begin
      run_frame(tbl[i].req, tbl[i].d0, tbl[i].d1, fack, word, nv, ngap);
      $display("[TB] frame %0d req=%b ack=%b word=%h valid=%0d gap=%0d", i, tbl[i].req, fack, word, nv, ngap);
      expect_eq($sformatf("tbl%0d_ack", i), {30'd0, fack}, {30'd0, tbl[i].exp_ack});
      expect_eq($sformatf("tbl%0d_word", i), word, tbl[i].exp_word);
      expect_eq($sformatf("tbl%0d_valid_cycles", i), nv, 32'd16);
      expect_eq($sformatf("tbl%0d_gap_cycles", i), ngap, IFG - 1);
    end

    // Both requesters held: grants alternate (or stay on 0) and frames start 64 cycles apart.
    pulse_reset("reset_before_tie");
    req = 2'b11; data0 = 32'h0000_0000; data1 = 32'hFFFF_FFFF;
    for (int c = 0; c < 400 && gcyc.size() < 4; c++) begin
      step();
      if (ack != 2'b00) begin
        gcyc.push_back(cyc);
        gwin.push_back(ack[1] ? 1 : 0);
      end
    end
    expect_eq("tie_grant_count", gcyc.size(), 32'd4);
    for (int i = 0; i < gwin.size(); i++) begin
`ifdef TX_ARBITER_FIXED_PRIORITY_EN
      expect_eq($sformatf("tie_winner%0d", i), gwin[i], 32'd0);
`else
      expect_eq($sformatf("tie_winner%0d", i), gwin[i], i % 2);
`endif
      if (i > 0) expect_eq($sformatf("tie_spacing%0d", i), gcyc[i] - gcyc[i-1], 32'd64);
    end
    $display("[TB] tie sequence grants=%0d", gcyc.size());
    drain();

    // Request raised during the gap is held off until the IDLE edge.
    req = 2'b01; data0 = 32'h1234_5678; data1 = 32'h3C3C_A5A5;
    step();
    t = cyc;
    req = 2'b00;
    repeat (20) step();
    req = 2'b10;
    for (int c = 0; c < 100 && ack == 2'b00; c++) step();
    expect_eq("gap_req_ack", {30'd0, ack}, 32'd2);
    expect_eq("gap_req_latency", cyc - t, 32'd64);
    $display("[TB] gap request granted ack=%b after %0d cycles", ack, cyc - t);
    drain();

    // Reset at the 8th dibit truncates the frame; the next frame starts without a gap.
    req = 2'b01; data0 = 32'hFEED_BEEF;
    step();
    req = 2'b00;
    repeat (7) step();
    expect_eq("pre_reset_valid", {31'd0, axiov}, 32'd1);
    pulse_reset("reset_mid_frame");
    req = 2'b01; data0 = 32'hA5C3_0FF0;
    step();
    expect_eq("post_reset_ack", {30'd0, ack}, 32'd1);
    req = 2'b00;
    $display("[TB] reset mid-frame, restart ack=%b", ack);
    drain();

    // Randomized traffic with withdrawals, data churn and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 9);
      req   = (r < 5) ? 2'b00 : (r < 7) ? 2'b01 : (r < 8) ? 2'b10 : 2'b11;
      data0 = $urandom;
      data1 = $urandom;
      if ($urandom_range(0, 499) == 0) pulse_reset("random_reset");
      else step();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
